// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// LC-3b control decoder with an LDI/STI two-phase sequencer feeding a STAGES-deep control pipeline.
// Latency: one edge to ctrl_ex; ready = idle & !stall; stall freezes everything; flush advances and inserts a bubble.
module control_sequencer #(
  parameter int STAGES       = 3,
  parameter int SUPPORT_IND  = 1,
  parameter int SUPPORT_BYTE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instruction,
  input  logic        stall,
  input  logic        flush,
  output logic        ready,
  output logic [23:0] ctrl_ex,
  output logic [23:0] ctrl_mem,
  output logic [23:0] ctrl_wb,
  output logic        illegal
);

  typedef struct packed {
    logic       byte_op;
    logic       valid;
    logic       pc_redirect;
    logic       indirect;
    logic       load_cc;
    logic       load_regfile;
    logic [2:0] regfilemux_sel;
    logic [1:0] mem_byte_enable;
    logic       mem_write;
    logic       mem_read;
    logic       sr2mux_sel;
    logic [2:0] alumux_selb;
    logic [2:0] alumux_sela;
    logic [3:0] aluop;
  } ctrl_t;

  localparam logic [0:0] S_NORM = 1'b0;
  localparam logic [0:0] S_IND2 = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NOT  = 4'd2;
  localparam logic [3:0] ALU_PASS = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SHF  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  logic [0:0] r_state;
  logic       r_ind_store;
  logic       r_illegal;
  ctrl_t      r_stage [STAGES];

  logic [3:0] w_op;
  ctrl_t      w_dec;
  ctrl_t      w_ph2;
  ctrl_t      w_new;
  logic       w_dec_ill;
  logic       w_dec_ind;
  logic       w_accept;
  logic       w_unused;

  assign w_op     = instruction[15:12];
  assign w_unused = ^{instruction[11:6], instruction[3:0]};

  always_comb begin
    w_dec     = '0;
    w_dec_ill = 1'b0;
    w_dec_ind = 1'b0;
    case (w_op)
      OP_ADD, OP_AND: begin
        w_dec.aluop        = (w_op == OP_AND) ? ALU_AND : ALU_ADD;
        w_dec.alumux_selb  = instruction[5] ? 3'b010 : 3'b000;
        w_dec.load_regfile = 1'b1;
        w_dec.load_cc      = 1'b1;
        w_dec.valid        = 1'b1;
      end
      OP_NOT: begin
        w_dec.aluop        = ALU_NOT;
        w_dec.load_regfile = 1'b1;
        w_dec.load_cc      = 1'b1;
        w_dec.valid        = 1'b1;
      end
      OP_SHF: begin
        w_dec.aluop        = !instruction[4] ? ALU_SLL : (!instruction[5] ? ALU_SRL : ALU_SRA);
        w_dec.alumux_selb  = 3'b101;
        w_dec.load_regfile = 1'b1;
        w_dec.load_cc      = 1'b1;
        w_dec.valid        = 1'b1;
      end
      OP_LDR: begin
        w_dec.alumux_selb     = 3'b001;
        w_dec.mem_read        = 1'b1;
        w_dec.mem_byte_enable = 2'b11;
        w_dec.regfilemux_sel  = 3'b001;
        w_dec.load_regfile    = 1'b1;
        w_dec.load_cc         = 1'b1;
        w_dec.valid           = 1'b1;
      end
      OP_STR: begin
        w_dec.alumux_selb     = 3'b001;
        w_dec.sr2mux_sel      = 1'b1;
        w_dec.mem_write       = 1'b1;
        w_dec.mem_byte_enable = 2'b11;
        w_dec.valid           = 1'b1;
      end
      // Byte lanes stay 00 here; MEM picks them from the address LSB.
      OP_LDB, OP_STB: begin
        if (SUPPORT_BYTE != 0) begin
          w_dec.alumux_selb = 3'b110;
          w_dec.byte_op     = 1'b1;
          w_dec.valid       = 1'b1;
          if (w_op == OP_LDB) begin
            w_dec.mem_read       = 1'b1;
            w_dec.regfilemux_sel = 3'b001;
            w_dec.load_regfile   = 1'b1;
            w_dec.load_cc        = 1'b1;
          end else begin
            w_dec.sr2mux_sel = 1'b1;
            w_dec.mem_write  = 1'b1;
          end
        end else begin
          w_dec_ill = 1'b1;
        end
      end
      OP_LEA: begin
        w_dec.alumux_sela  = 3'b100;
        w_dec.alumux_selb  = 3'b100;
        w_dec.load_regfile = 1'b1;
        w_dec.valid        = 1'b1;
      end
      OP_BR, OP_JMP, OP_JSR, OP_TRAP: begin
        w_dec.aluop       = ALU_PASS;
        w_dec.pc_redirect = 1'b1;
        w_dec.valid       = 1'b1;
      end
      OP_LDI, OP_STI: begin
        if (SUPPORT_IND != 0) begin
          w_dec.alumux_selb     = 3'b001;
          w_dec.mem_read        = 1'b1;
          w_dec.mem_byte_enable = 2'b11;
          w_dec.indirect        = 1'b1;
          w_dec.valid           = 1'b1;
          w_dec_ind             = 1'b1;
        end else begin
          w_dec_ill = 1'b1;
        end
      end
      default: w_dec_ill = 1'b1;
    endcase
  end

  // Second memory phase uses the pointer fetched by phase 1 (sela 011).
  always_comb begin
    w_ph2                 = '0;
    w_ph2.aluop           = ALU_PASS;
    w_ph2.alumux_sela     = 3'b011;
    w_ph2.mem_byte_enable = 2'b11;
    w_ph2.valid           = 1'b1;
    if (r_ind_store) begin
      w_ph2.mem_write  = 1'b1;
      w_ph2.sr2mux_sel = 1'b1;
    end else begin
      w_ph2.mem_read       = 1'b1;
      w_ph2.regfilemux_sel = 3'b001;
      w_ph2.load_regfile   = 1'b1;
      w_ph2.load_cc        = 1'b1;
    end
  end

  assign ready    = (r_state == S_NORM) & ~stall;
  assign w_accept = instr_valid & ready;

  always_comb begin
    w_new = '0;
    if (r_state == S_IND2) begin
      w_new = w_ph2;
    end else if (w_accept && !w_dec_ill) begin
      w_new = w_dec;
    end
  end

  // flush wins over stall: older words still drain while the youngest is killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_NORM;
      r_ind_store <= 1'b0;
      r_illegal   <= 1'b0;
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else if (flush || !stall) begin
      for (int i = STAGES - 1; i > 0; i--) r_stage[i] <= r_stage[i-1];
      if (flush) begin
        r_stage[0] <= '0;
        r_state    <= S_NORM;
        r_illegal  <= 1'b0;
      end else begin
        r_stage[0] <= w_new;
        r_illegal  <= w_accept & w_dec_ill;
        if (r_state == S_IND2) begin
          r_state <= S_NORM;
        end else if (w_accept && w_dec_ind) begin
          r_state     <= S_IND2;
          r_ind_store <= w_op[0];
        end
      end
    end
  end

  assign ctrl_ex  = r_stage[0];
  assign ctrl_mem = r_stage[STAGES-2];
  assign ctrl_wb  = r_stage[STAGES-1];
  assign illegal  = r_illegal;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised successor to the single-cycle LC-3b control decoder.
- Decodes each accepted instruction into one or two micro-op control words: LDI/STI are split into two memory phases by an internal sequencer.
- Carries the control words through a stall/flush-aware shift pipeline and presents the EX, MEM and WB stage copies to the datapath.
- Sits between the ID stage register and the EX/MEM/WB datapath muxes.

Parameters:
- STAGES, 3: number of control pipeline registers after decode; legal range 3..6; extra stages model added memory latency.
- SUPPORT_IND, 1: 1 = LDI/STI run as two micro-ops; 0 = LDI/STI are illegal.
- SUPPORT_BYTE, 1: 1 = LDB/STB decoded; 0 = LDB/STB are illegal.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction is present on instruction.
- instruction  in  16  LC-3b instruction word.
- stall  in  1  hold the whole control pipeline.
- flush  in  1  kill the youngest micro-op and any pending LDI/STI phase 2.
- ready  out  1  instruction is accepted this cycle; combinational = (state==S_NORM) & !stall.
- ctrl_ex  out  24  stage[0] control word.
- ctrl_mem  out  24  stage[STAGES-2] control word.
- ctrl_wb  out  24  stage[STAGES-1] control word.
- illegal  out  1  one-cycle registered pulse when an illegal opcode is accepted.

Behaviour:
- Control word layout:
  - [3:0] aluop (add=0, and=1, not=2, pass=3, sll=4, srl=5, sra=6)
  - [6:4] alumux_sela; [9:7] alumux_selb; [10] sr2mux_sel
  - [11] mem_read; [12] mem_write; [14:13] mem_byte_enable
  - [17:15] regfilemux_sel; [18] load_regfile; [19] load_cc
  - [20] indirect (phase 1 of LDI/STI); [21] pc_redirect; [22] valid; [23] byte_op
  - Bubble = all zero.
- Decode table (fields not listed are 0):
  - ADD/AND: aluop add/and, load_regfile, load_cc, valid; alumux_selb = 010 if instr[5] else 000.
  - NOT: aluop not, load_regfile, load_cc, valid.
  - SHF: alumux_selb 101, load_regfile, load_cc, valid; aluop = sll if instr[4]==0, else srl if instr[5]==0, else sra.
  - LDR: add, selb 001, mem_read, be 11, regfilemux 001, load_regfile, load_cc, valid.
  - STR: add, selb 001, sr2mux_sel, mem_write, be 11, valid.
  - LDB/STB: as LDR/STR but selb 110, be 00, byte_op=1; MEM resolves lanes from the address LSB.
  - LEA: add, sela 100, selb 100, load_regfile, valid.
  - BR/JMP/JSR/TRAP: pc_redirect, valid, aluop pass.
  - RTI and any disabled opcode: bubble + illegal.
- Sequencer FSM, states S_NORM and S_IND2:
  - S_NORM, accept of LDI/STI with SUPPORT_IND=1: emit phase 1 (add, selb 001, mem_read, be 11, indirect, valid); go to S_IND2; ready=0.
  - S_IND2, !stall: emit phase 2 (aluop pass, sela 011, be 11, valid).
    - LDI phase 2 adds mem_read, regfilemux 001, load_regfile, load_cc.
    - STI phase 2 adds mem_write, sr2mux_sel.
    - Then return to S_NORM.
- Pipeline advance:
  - stall=0: stage[i] <= stage[i-1]; stage[0] <= new micro-op, or bubble if nothing is accepted or emitted.
  - stall=1: all stages, FSM and illegal hold.
  - flush=1 overrides stall: stages advance, stage[0] <= bubble, FSM -> S_NORM (phase 2 dropped), illegal <= 0.
- Latency: a word accepted at edge N appears on ctrl_ex after edge N and on ctrl_wb after edge N+STAGES-1, with no stalls.
- Reset: all stages 0, FSM S_NORM, illegal 0. ready is 1 whenever stall=0. Reset mid-LDI discards phase 2.
- instr_valid while ready=0 is ignored; upstream must hold the instruction.

Test Plan:
- Reset, then ADD R1,R2,R3 (0x1283), no stall -> ctrl_ex=0x4C0000 after 1 edge, ctrl_mem after 2, ctrl_wb after 3 (STAGES=3); ADD imm 0x12A5 -> 0x4C0100.
- LDR 0x6283 -> 0x4CE880; LDI 0xA283 -> ready=0 for one cycle, then ctrl_ex shows phase 1 (indirect=1, mem_read=1, regfile=0) followed by phase 2 (aluop 3, sela 011, load_regfile=1, load_cc=1).
- STI with stall raised in S_IND2 for 3 cycles -> all ctrl outputs frozen, ready=0; phase 2 (mem_write=1, sr2mux_sel=1) emitted on the first unstalled edge.
- flush in S_IND2 -> ctrl_ex=0 next edge, phase 2 never emitted, ready=1; simultaneous flush+stall -> older stages still advance.
- RTI 0x8000 and, with SUPPORT_BYTE=0, LDB 0x2283 -> bubble in ctrl_ex, illegal=1 for exactly one cycle.
- Assert reset asynchronously mid-pipeline (between edges) -> all ctrl outputs 0 immediately, illegal 0, next LDI starts in phase 1.
